// File: rtl/multiple_clk_pkg.sv
// Shared constants and helpers for the multiple_clk dual-rate register block.
package multiple_clk_pkg;

  localparam int DIV1_DEFAULT = 5;
  localparam int DIV2_DEFAULT = 4;

  // Divider counter width; a divide-by-1 still needs a 1-bit register.
  function automatic int cnt_w(input int div);
    if (div <= 1) begin
      return 1;
    end else begin
      return $clog2(div);
    end
  endfunction

endpackage

// File: rtl/multiple_clk_tick_gen.sv
// Clock-enable generator: tick is high for one clk out of every DIV.
module multiple_clk_tick_gen
  import multiple_clk_pkg::*;
#(
  parameter int DIV = DIV1_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  if (DIV < 1) begin : g_div_check
    $fatal(1, "multiple_clk_tick_gen: DIV must be >= 1");
  end

  logic [W-1:0] cnt_r;

  // Phase counter: 0..DIV-1, wraps on the tick cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/multiple_clk.sv
// Dual-rate registered logic: f1 = a & b every DIV1 clks, f2 = b ^ c every DIV2 clks.
// Define MULTIPLE_CLK_TICK_OUT_EN to expose the tick strobes as tick1_o / tick2_o.
module multiple_clk
  import multiple_clk_pkg::*;
#(
  parameter int DIV1 = DIV1_DEFAULT,
  parameter int DIV2 = DIV2_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f1,
  output logic f2
`ifdef MULTIPLE_CLK_TICK_OUT_EN
  ,
  output logic tick1_o,
  output logic tick2_o
`endif
);

  logic tick1_s;
  logic tick2_s;
  logic f1_r;
  logic f2_r;

  multiple_clk_tick_gen #(.DIV(DIV1)) u_tick1 (
    .clk  (clk),
    .rst  (rst),
    .tick (tick1_s)
  );

  multiple_clk_tick_gen #(.DIV(DIV2)) u_tick2 (
    .clk  (clk),
    .rst  (rst),
    .tick (tick2_s)
  );

  // f1 samples a & b only on tick1 edges
  always_ff @(posedge clk) begin
    if (rst) begin
      f1_r <= 1'b0;
    end else if (tick1_s) begin
      f1_r <= a & b;
    end else begin
      f1_r <= f1_r;
    end
  end

  // f2 samples b ^ c only on tick2 edges
  always_ff @(posedge clk) begin
    if (rst) begin
      f2_r <= 1'b0;
    end else if (tick2_s) begin
      f2_r <= b ^ c;
    end else begin
      f2_r <= f2_r;
    end
  end

  assign f1 = f1_r;
  assign f2 = f2_r;

`ifdef MULTIPLE_CLK_TICK_OUT_EN
  // A divide-by-1 counter ticks during reset too, so mask with rst.
  assign tick1_o = tick1_s & ~rst;
  assign tick2_o = tick2_s & ~rst;
`endif

endmodule

// File: tb/tb_multiple_clk.sv
// Self-checking bench for multiple_clk: default DIV1=5/DIV2=4 instance plus a DIV=1 instance.
module tb_multiple_clk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b1;
  logic b = 1'b1;
  logic c = 1'b1;
  logic f1_m, f2_m;
  logic f1_d, f2_d;
`ifdef MULTIPLE_CLK_TICK_OUT_EN
  logic t1_m, t2_m, t1_d, t2_d;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic rst;
    logic a;
    logic b;
    logic c;
    logic f1;
    logic f2;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  multiple_clk dut_main (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .f1  (f1_m),
    .f2  (f2_m)
`ifdef MULTIPLE_CLK_TICK_OUT_EN
    ,
    .tick1_o (t1_m),
    .tick2_o (t2_m)
`endif
  );

  multiple_clk #(.DIV1(1), .DIV2(1)) dut_div1 (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .f1  (f1_d),
    .f2  (f2_d)
`ifdef MULTIPLE_CLK_TICK_OUT_EN
    ,
    .tick1_o (t1_d),
    .tick2_o (t2_d)
`endif
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic va, input logic vb, input logic vc,
                     input logic ef1, input logic ef2, input int n);
    vec_t v;
    v.rst = r; v.a = va; v.b = vb; v.c = vc; v.f1 = ef1; v.f2 = ef2;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  initial begin
    // Reset: 3 edges with all operands high
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    // Rate check: a=1 b=1 c=0; f2 at edge 4, f1 at edge 5
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    // Hold check: a=1 b=0 c=1 from edge 6; f2 stays 1 at 8, f1 drops at 10
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    // Edges 11-16 with a=1 b=1 c=0: f1 rises at 15, f2 reloads 1 at 12/16
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    // Coincident ticks: a=0 b=1 c=1 edges 17-20, both fall together at 20
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    // Restart, then reset mid-operation after edge 7 (counters non-zero)
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    // Tick phase restarts: f2 at 4 edges, f1 at 5 edges after release
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst;
      a   = vq[i].a;
      b   = vq[i].b;
      c   = vq[i].c;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_f1", i), f1_m, vq[i].f1);
      check($sformatf("vec%0d_f2", i), f2_m, vq[i].f2);
      check($sformatf("vec%0d_div1_f1", i), f1_d, vq[i].rst ? 1'b0 : (vq[i].a & vq[i].b));
      check($sformatf("vec%0d_div1_f2", i), f2_d, vq[i].rst ? 1'b0 : (vq[i].b ^ vq[i].c));
`ifdef MULTIPLE_CLK_TICK_OUT_EN
      check($sformatf("vec%0d_div1_tick1", i), t1_d, ~vq[i].rst);
      check($sformatf("vec%0d_div1_tick2", i), t2_d, ~vq[i].rst);
`endif
    end

    // DIV=1: operands change every cycle, outputs follow with one-cycle latency
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      logic pf1, pf2;
      p = 3'(i * 5 + 1);
      {a, b, c} = p;
      pf1 = f1_d;
      pf2 = f2_d;
      #3;
      check($sformatf("div1_hold%0d_f1", i), f1_d, pf1);
      check($sformatf("div1_hold%0d_f2", i), f2_d, pf2);
      @(posedge clk);
      #1;
      check($sformatf("div1_seq%0d_f1", i), f1_d, p[2] & p[1]);
      check($sformatf("div1_seq%0d_f2", i), f2_d, p[1] ^ p[0]);
`ifdef MULTIPLE_CLK_TICK_OUT_EN
      check($sformatf("div1_seq%0d_tick1", i), t1_d, 1'b1);
      check($sformatf("div1_seq%0d_tick2", i), t2_d, 1'b1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
